am_modulator: RTL and testbench

Transmit-side counterpart of the AM demodulator. Accepts signed 8-bit audio samples over a valid/ready handshake and forms the AM envelope (carrier level plus scaled audio). It multiplies the envelope by a quadrature NCO carrier and emits signed 8-bit I/Q samples with a one-cycle valid strobe. A single registered 8x8 signed multiplier is time-shared between the I and Q products.

---
 rtl/am_pkg.sv | 43 ++++
 rtl/am_sin_lut.sv | 23 ++
 rtl/am_modulator.sv | 143 ++++++++++++++
 tb/tb_am_modulator.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/am_pkg.sv
// Shared types and constants for the AM modulator: FSM states, datapath widths,
// and the quarter-wave sine table used by am_sin_lut.
package am_pkg;

  localparam int unsigned SAMPLE_W   = 8;
  localparam int unsigned PHASE_W    = 16;
  localparam int unsigned LUT_IDX_W  = 8;
  localparam int unsigned ENV_W      = 7;
  localparam int unsigned ENV_SUM_W  = 9;
  localparam int unsigned PROD_W     = 16;
  localparam int unsigned FRAC_SHIFT = 7;
  localparam int unsigned QTR_J_W    = 6;
  localparam int unsigned QTR_ADDR_W = 7;
  localparam int unsigned QTR_SIZE   = 65;

  typedef enum logic [2:0] {
    IDLE,
    ENV,
    MUL_I,
    MUL_Q,
    DONE
  } am_state_t;

  // Sample captured at handshake: audio plus the 8-bit carrier phase it rides on
  typedef struct packed {
    logic signed [SAMPLE_W-1:0]  audio;
    logic        [LUT_IDX_W-1:0] phase;
  } am_sample_t;

  // round(127*sin(2*pi*k/256)) for k = 0..64
  localparam logic [QTR_ADDR_W-1:0] QTR_TABLE [QTR_SIZE] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
    7'd127
  };

endpackage

// File: rtl/am_sin_lut.sv
// Combinational full-wave sine built from the quarter-wave table by quadrant folding.
module am_sin_lut
  import am_pkg::*;
(
  input  logic        [LUT_IDX_W-1:0] phase,
  output logic signed [SAMPLE_W-1:0]  sin_c
);

  logic [1:0]            quad;
  logic [QTR_J_W-1:0]    j;
  logic [QTR_ADDR_W-1:0] addr;
  logic [QTR_ADDR_W-1:0] mag;

  // Odd quadrants mirror the index, the lower half-wave negates the magnitude
  always_comb begin
    quad  = phase[LUT_IDX_W-1 -: 2];
    j     = phase[QTR_J_W-1:0];
    addr  = quad[0] ? (QTR_ADDR_W'(QTR_SIZE - 1) - QTR_ADDR_W'(j)) : QTR_ADDR_W'(j);
    mag   = QTR_TABLE[addr];
    sin_c = quad[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  end

endmodule

// File: rtl/am_modulator.sv
// AM modulator: envelope (carrier + scaled audio) times a quadrature NCO carrier,
// one shared registered multiplier. Define AM_MOD_SATURATE_EN to clamp the envelope.
module am_modulator
  import am_pkg::*;
#(
  parameter int unsigned CARRIER_LVL = 64,
  parameter int unsigned MOD_SHIFT   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] audio_in,
  input  logic                       audio_valid,
  output logic                       audio_ready,
  input  logic        [PHASE_W-1:0]  phase_inc,
  output logic signed [SAMPLE_W-1:0] I_out,
  output logic signed [SAMPLE_W-1:0] Q_out,
  output logic                       out_valid
);

  am_state_t state, state_next;

  logic latch_en, env_en, sel_sin, cap_i, done_en;

  logic        [PHASE_W-1:0]   phase_acc;
  am_sample_t                  smp;
  logic        [LUT_IDX_W-1:0] cos_phase;
  logic signed [SAMPLE_W-1:0]  sin_c, cos_c, sin_q, cos_q, mul_b;
  logic signed [ENV_SUM_W-1:0] audio_ext, env_sum;
  logic        [ENV_W-1:0]     env_c, env_q;
  logic signed [PROD_W-1:0]    mul_a16, mul_b16, prod_q, prod_i_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (audio_valid && audio_ready) state_next = ENV;
      ENV:     state_next = MUL_I;
      MUL_I:   state_next = MUL_Q;
      MUL_Q:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-state datapath strobes
  always_comb begin
    latch_en = 1'b0;
    env_en   = 1'b0;
    sel_sin  = 1'b0;
    cap_i    = 1'b0;
    done_en  = 1'b0;
    case (state)
      IDLE:    latch_en = audio_valid && audio_ready;
      ENV:     env_en   = 1'b1;
      MUL_I:   sel_sin  = 1'b0;
      MUL_Q:   begin sel_sin = 1'b1; cap_i = 1'b1; end
      DONE:    done_en  = 1'b1;
      default: ;
    endcase
  end

  // Sample capture; phase seen by this sample is the accumulator before its own step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_acc <= '0;
      smp       <= '0;
    end else if (latch_en) begin
      smp.audio <= audio_in;
      smp.phase <= phase_acc[PHASE_W-1 -: LUT_IDX_W];
      phase_acc <= phase_acc + phase_inc;
    end
  end

  assign audio_ext = {smp.audio[SAMPLE_W-1], smp.audio};
  assign env_sum   = $signed(ENV_SUM_W'(CARRIER_LVL)) + (audio_ext >>> MOD_SHIFT);

  // Envelope limiting to the 7-bit unsigned range
  always_comb begin
`ifdef AM_MOD_SATURATE_EN
    if (env_sum < 9'sd0)        env_c = '0;
    else if (env_sum > 9'sd127) env_c = '1;
    else                        env_c = env_sum[ENV_W-1:0];
`else
    env_c = env_sum[ENV_W-1:0];
`endif
  end

  assign cos_phase = smp.phase + LUT_IDX_W'(QTR_SIZE - 1);

  am_sin_lut u_sin (.phase(smp.phase), .sin_c(sin_c));
  am_sin_lut u_cos (.phase(cos_phase), .sin_c(cos_c));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_q <= '0;
      sin_q <= '0;
      cos_q <= '0;
    end else if (env_en) begin
      env_q <= env_c;
      sin_q <= sin_c;
      cos_q <= cos_c;
    end
  end

  // Shared multiplier: envelope is non-negative, so zero-extend before signed multiply
  assign mul_b   = sel_sin ? sin_q : cos_q;
  assign mul_a16 = PROD_W'($signed({1'b0, env_q}));
  assign mul_b16 = PROD_W'(mul_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= '0;
      prod_i_q <= '0;
    end else begin
      prod_q <= mul_a16 * mul_b16;
      if (cap_i) prod_i_q <= prod_q;
    end
  end

  // Output and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      I_out       <= '0;
      Q_out       <= '0;
      out_valid   <= 1'b0;
      audio_ready <= 1'b1;
    end else begin
      out_valid   <= done_en;
      audio_ready <= (state_next == IDLE);
      if (done_en) begin
        I_out <= SAMPLE_W'(prod_i_q >>> FRAC_SHIFT);
        Q_out <= SAMPLE_W'(prod_q >>> FRAC_SHIFT);
      end
    end
  end

endmodule

// File: tb/tb_am_modulator.sv
// Bench for am_modulator: two instances (MOD_SHIFT 1 and 0) share stimulus and are
// checked against a real-valued sine/envelope model through a latency scoreboard.
`timescale 1ns/1ps
module tb_am_modulator;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [7:0]  audio_in = '0;
  logic               audio_valid = 1'b0;
  logic        [15:0] phase_inc = '0;
  logic               ready_a, ready_b, ov_a, ov_b;
  logic signed [7:0]  i_a, q_a, i_b, q_b;

  always #5 clk = ~clk;

  am_modulator #(.CARRIER_LVL(64), .MOD_SHIFT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .audio_in(audio_in), .audio_valid(audio_valid),
    .audio_ready(ready_a), .phase_inc(phase_inc), .I_out(i_a), .Q_out(q_a), .out_valid(ov_a));

  am_modulator #(.CARRIER_LVL(64), .MOD_SHIFT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .audio_in(audio_in), .audio_valid(audio_valid),
    .audio_ready(ready_b), .phase_inc(phase_inc), .I_out(i_b), .Q_out(q_b), .out_valid(ov_b));

  typedef struct {
    int ia, qa, ib, qb, due;
  } exp_t;

  typedef struct {
    logic signed [7:0] audio;
    logic [15:0]       inc;
    int                ia, qa, ib, qb;
  } row_t;

  exp_t        sb[$];
  row_t        rows[6];
  logic [15:0] model_phase = '0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  localparam real PI = 3.14159265358979;

  function automatic int sin_ref(input int n);
    real v;
    v = 127.0 * $sin(2.0 * PI * real'(n % 256) / 256.0);
    return int'(v);
  endfunction

  function automatic int env_ref(input int audio, input int shift);
    int e;
    e = 64 + (audio >>> shift);
`ifdef AM_MOD_SATURATE_EN
    if (e < 0) e = 0;
    else if (e > 127) e = 127;
`else
    e = e & 127;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: record a transfer happening at the coming edge, then check outputs
  task automatic tick();
    exp_t e;
    int   ph;
    if (!rst_n) begin
      sb.delete();
      model_phase = '0;
    end else if (audio_valid && ready_a) begin
      ph   = int'(model_phase[15:8]);
      e.ia = (env_ref(int'(audio_in), 1) * sin_ref(ph + 64)) >>> 7;
      e.qa = (env_ref(int'(audio_in), 1) * sin_ref(ph)) >>> 7;
      e.ib = (env_ref(int'(audio_in), 0) * sin_ref(ph + 64)) >>> 7;
      e.qb = (env_ref(int'(audio_in), 0) * sin_ref(ph)) >>> 7;
      e.due = cyc + 5;
      sb.push_back(e);
      model_phase = model_phase + phase_inc;
    end
    @(negedge clk);
    cyc++;
    chk("ready_match", int'(ready_b), int'(ready_a));
    chk("valid_match", int'(ov_b), int'(ov_a));
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("out_valid_latency", int'(ov_a), 1);
      if (ov_a) begin
        chk("i_shift1", int'(i_a), e.ia);
        chk("q_shift1", int'(q_a), e.qa);
        chk("i_shift0", int'(i_b), e.ib);
        chk("q_shift0", int'(q_b), e.qb);
      end
    end else begin
      chk("out_valid_idle", int'(ov_a), 0);
    end
  endtask

  task automatic send(input logic signed [7:0] a, input logic [15:0] inc);
    int n;
    n = 0;
    audio_in = a;
    phase_inc = inc;
    audio_valid = 1'b1;
    while (!ready_a && n < 20) begin tick(); n++; end
    chk("send_ready", int'(ready_a), 1);
    tick();
    audio_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!ov_a && n < 10) begin tick(); n++; end
    chk("wait_out_valid", int'(ov_a), 1);
  endtask

  initial begin
    int lo, prev;

    rows[0] = '{8'sd0,    16'h4000, 63,  0,   63,  0};
    rows[1] = '{8'sd0,    16'h4000, 0,   63,  0,   63};
    rows[2] = '{8'sd0,    16'h4000, -64, 0,   -64, 0};
    rows[3] = '{8'sd0,    16'h4000, 0,   -64, 0,   -64};
`ifdef AM_MOD_SATURATE_EN
    rows[4] = '{8'sd127,  16'h0000, 126, 0,   126, 0};
    rows[5] = '{-8'sd128, 16'h0000, 0,   0,   0,   0};
`else
    rows[4] = '{8'sd127,  16'h0000, 126, 0,   62,  0};
    rows[5] = '{-8'sd128, 16'h0000, 0,   0,   63,  0};
`endif

    // Reset state
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("reset_i", int'(i_a), 0);
    chk("reset_q", int'(q_a), 0);
    chk("reset_valid", int'(ov_a), 0);
    chk("reset_ready", int'(ready_a), 1);

    // Directed vectors: quadrant phases and envelope limits
    for (int r = 0; r < 6; r++) begin
      send(rows[r].audio, rows[r].inc);
      wait_out();
      chk($sformatf("row%0d_i_shift1", r), int'(i_a), rows[r].ia);
      chk($sformatf("row%0d_q_shift1", r), int'(q_a), rows[r].qa);
      chk($sformatf("row%0d_i_shift0", r), int'(i_b), rows[r].ib);
      chk($sformatf("row%0d_q_shift0", r), int'(q_b), rows[r].qb);
      tick();
      chk($sformatf("row%0d_pulse_width", r), int'(ov_a), 0);
    end

    // Reset pulsed while the sample sits in MUL_I
    send(8'sd50, 16'h1234);
    tick();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk("midrst_i", int'(i_a), 0);
    chk("midrst_q", int'(q_a), 0);
    send(8'sd0, 16'h4000);
    wait_out();
    chk("midrst_phase0_i", int'(i_a), 63);
    chk("midrst_phase0_q", int'(q_a), 0);

    // audio_valid held high: transfers every 5 cycles
    audio_valid = 1'b1;
    audio_in = 8'($urandom);
    phase_inc = 16'($urandom);
    prev = -1;
    for (int s = 0; s < 6; s++) begin
      lo = 0;
      while (!ready_a && lo < 20) begin tick(); lo++; end
      chk("b2b_ready", int'(ready_a), 1);
      if (prev >= 0) begin
        chk("b2b_spacing", cyc - prev, 5);
        chk("b2b_ready_low", lo, 4);
      end
      prev = cyc;
      tick();
      audio_in = 8'($urandom);
      phase_inc = 16'($urandom);
    end
    audio_valid = 1'b0;

    // Random samples with random idle gaps
    for (int s = 0; s < 40; s++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      send(8'($urandom), 16'($urandom));
    end

    for (int k = 0; k < 10; k++) tick();
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
